// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: round-robin multi-thread fetch address generator.
// Tracks per-thread PC/PID/TID and tags each fetch bundle with a major ID.
module fetch_pc_sequencer #(
   parameter int addressWidth = 64,
   parameter int bundleInsts = 4,
   parameter int numThreads = 2,
   parameter int PidSize = 32,
   parameter int TidSize = 64,
   parameter int instructionCounterWidth = 64,
   parameter logic [addressWidth-1:0] resetVector = '0,
   localparam int TW = (numThreads > 1) ? $clog2(numThreads) : 1,
   localparam int CW = $clog2(bundleInsts + 1)
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               stall_i,
   input  logic [numThreads-1:0]              threadEnable_i,
   input  logic                               redirectEn_i,
   input  logic [TW-1:0]                      redirectThread_i,
   input  logic [addressWidth-1:0]            redirectAddress_i,
   input  logic                               incEnable_i,
   input  logic [CW-1:0]                      incCount_i,
   input  logic                               pidWriteEn_i,
   input  logic                               tidWriteEn_i,
   input  logic [TW-1:0]                      idThread_i,
   input  logic [PidSize-1:0]                 pid_i,
   input  logic [TidSize-1:0]                 tid_i,
   output logic                               fetchValid_o,
   output logic [addressWidth-1:0]            fetchAddress_o,
   output logic [TW-1:0]                      fetchThread_o,
   output logic [PidSize-1:0]                 fetchPid_o,
   output logic [TidSize-1:0]                 fetchTid_o,
   output logic [instructionCounterWidth-1:0] fetchMajId_o
);

   localparam logic [addressWidth-1:0] STEP =
      addressWidth'(4 * bundleInsts);
   localparam logic [instructionCounterWidth-1:0] BINC =
      instructionCounterWidth'(bundleInsts);
   localparam logic [addressWidth-1:0] ALIGN_MASK =
      ~addressWidth'(3);

   logic [addressWidth-1:0]            pc_q [numThreads];
   logic [addressWidth-1:0]            pc_d [numThreads];
   logic [PidSize-1:0]                 pid_q [numThreads];
   logic [TidSize-1:0]                 tid_q [numThreads];
   logic [TW-1:0]                      rr_q;
   logic [instructionCounterWidth-1:0] cnt_q;

   logic [numThreads-1:0] elig;
   logic                  any_elig;
   logic [TW-1:0]         sel;
   logic                  issue;
   logic                  drop_held;
   logic [addressWidth-1:0] inc_addr;
   logic [addressWidth-1:0] redir_addr;

   // A thread being redirected this cycle must not issue from its stale PC.
   always_comb begin
      elig = '0;
      for (int t = 0; t < numThreads; t++) begin
         elig[t] = threadEnable_i[t] &&
            !(redirectEn_i && (redirectThread_i == TW'(t)));
      end
   end

   assign any_elig = |elig;

   // Scan from farthest to nearest so the nearest candidate wins.
   always_comb begin
      sel = '0;
      for (int k = numThreads; k >= 1; k--) begin
         for (int t = 0; t < numThreads; t++) begin
            if (elig[t] && (t == ((int'(rr_q) + k) % numThreads))) begin
               sel = TW'(t);
            end
         end
      end
   end

   assign issue = !stall_i && !incEnable_i && any_elig;

   assign drop_held = stall_i && fetchValid_o && redirectEn_i &&
      (redirectThread_i == fetchThread_o);

   assign inc_addr = fetchAddress_o + addressWidth'({incCount_i, 2'b00});
   assign redir_addr = redirectAddress_i & ALIGN_MASK;

   // Redirect is applied last so it overrides a partial-bundle correction.
   always_comb begin
      for (int t = 0; t < numThreads; t++) begin
         pc_d[t] = pc_q[t];
         if (issue && (sel == TW'(t))) begin
            pc_d[t] = pc_q[t] + STEP;
         end
         if (incEnable_i && (fetchThread_o == TW'(t))) begin
            pc_d[t] = inc_addr;
         end
         if (redirectEn_i && (redirectThread_i == TW'(t))) begin
            pc_d[t] = redir_addr;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int t = 0; t < numThreads; t++) begin
            pc_q[t]  <= resetVector;
            pid_q[t] <= '0;
            tid_q[t] <= '0;
         end
         rr_q           <= TW'(numThreads - 1);
         cnt_q          <= '0;
         fetchValid_o   <= 1'b0;
         fetchAddress_o <= '0;
         fetchThread_o  <= '0;
         fetchPid_o     <= '0;
         fetchTid_o     <= '0;
         fetchMajId_o   <= '0;
      end else begin
         for (int t = 0; t < numThreads; t++) begin
            pc_q[t] <= pc_d[t];
            if (pidWriteEn_i && (idThread_i == TW'(t))) begin
               pid_q[t] <= pid_i;
            end
            if (tidWriteEn_i && (idThread_i == TW'(t))) begin
               tid_q[t] <= tid_i;
            end
         end
         if (stall_i) begin
            if (drop_held) begin
               fetchValid_o <= 1'b0;
            end
         end else if (issue) begin
            fetchValid_o   <= 1'b1;
            fetchAddress_o <= pc_q[sel];
            fetchThread_o  <= sel;
            fetchPid_o     <= pid_q[sel];
            fetchTid_o     <= tid_q[sel];
            fetchMajId_o   <= cnt_q;
            rr_q           <= sel;
            cnt_q          <= cnt_q + BINC;
         end else begin
            fetchValid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed scoreboard bench for fetch_pc_sequencer.
// Counter width reduced to 8 bits so the major-ID wrap is reachable.
module tb_fetch_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        stall_i;
   logic [1:0]  threadEnable_i;
   logic        redirectEn_i;
   logic [0:0]  redirectThread_i;
   logic [63:0] redirectAddress_i;
   logic        incEnable_i;
   logic [2:0]  incCount_i;
   logic        pidWriteEn_i;
   logic        tidWriteEn_i;
   logic [0:0]  idThread_i;
   logic [31:0] pid_i;
   logic [63:0] tid_i;
   logic        fetchValid_o;
   logic [63:0] fetchAddress_o;
   logic [0:0]  fetchThread_o;
   logic [31:0] fetchPid_o;
   logic [63:0] fetchTid_o;
   logic [7:0]  fetchMajId_o;

   int total = 0;
   int bad = 0;
   int stepno = 0;

   typedef struct {
      logic        v;
      logic [63:0] a;
      logic        t;
      logic [7:0]  m;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   fetch_pc_sequencer #(
      .addressWidth(64),
      .bundleInsts(4),
      .numThreads(2),
      .PidSize(32),
      .TidSize(64),
      .instructionCounterWidth(8),
      .resetVector(64'h0)
   ) dut (
      .clock_i(clk),
      .reset_i(reset_i),
      .stall_i(stall_i),
      .threadEnable_i(threadEnable_i),
      .redirectEn_i(redirectEn_i),
      .redirectThread_i(redirectThread_i),
      .redirectAddress_i(redirectAddress_i),
      .incEnable_i(incEnable_i),
      .incCount_i(incCount_i),
      .pidWriteEn_i(pidWriteEn_i),
      .tidWriteEn_i(tidWriteEn_i),
      .idThread_i(idThread_i),
      .pid_i(pid_i),
      .tid_i(tid_i),
      .fetchValid_o(fetchValid_o),
      .fetchAddress_o(fetchAddress_o),
      .fetchThread_o(fetchThread_o),
      .fetchPid_o(fetchPid_o),
      .fetchTid_o(fetchTid_o),
      .fetchMajId_o(fetchMajId_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL step%0d %s obs=%h exp=%h", stepno, tag, obs, exp);
      end
   endtask

   // Push expectation, clock once, then pop and compare.
   task automatic step(input logic v, input logic [63:0] a,
                       input logic t, input logic [7:0] m);
      exp_t e;
      e.v = v;
      e.a = a;
      e.t = t;
      e.m = m;
      sbq.push_back(e);
      stepno++;
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk("valid", 64'(fetchValid_o), 64'(e.v));
      if (e.v) begin
         chk("addr", fetchAddress_o, e.a);
         chk("thread", 64'(fetchThread_o), 64'(e.t));
         chk("majid", 64'(fetchMajId_o), 64'(e.m));
      end
      redirectEn_i = 1'b0;
      incEnable_i = 1'b0;
      pidWriteEn_i = 1'b0;
      tidWriteEn_i = 1'b0;
   endtask

   task automatic redirect(input logic t, input logic [63:0] a);
      redirectEn_i = 1'b1;
      redirectThread_i = t;
      redirectAddress_i = a;
   endtask

   initial begin
      reset_i = 1'b1;
      stall_i = 1'b0;
      threadEnable_i = 2'b11;
      redirectEn_i = 1'b0;
      redirectThread_i = '0;
      redirectAddress_i = '0;
      incEnable_i = 1'b0;
      incCount_i = '0;
      pidWriteEn_i = 1'b0;
      tidWriteEn_i = 1'b0;
      idThread_i = '0;
      pid_i = '0;
      tid_i = '0;

      // reset state
      step(1'b0, 64'h0, 1'b0, 8'd0);
      chk("rst_addr", fetchAddress_o, 64'h0);
      chk("rst_thr", 64'(fetchThread_o), 64'h0);
      chk("rst_pid", 64'(fetchPid_o), 64'h0);
      chk("rst_tid", fetchTid_o, 64'h0);
      chk("rst_maj", 64'(fetchMajId_o), 64'h0);
      reset_i = 1'b0;

      // alternating round robin
      step(1'b1, 64'h0, 1'b0, 8'd0);
      step(1'b1, 64'h0, 1'b1, 8'd4);
      step(1'b1, 64'h10, 1'b0, 8'd8);
      step(1'b1, 64'h10, 1'b1, 8'd12);

      // id write is not visible to the same-cycle issue
      pidWriteEn_i = 1'b1;
      tidWriteEn_i = 1'b1;
      idThread_i = 1'b0;
      pid_i = 32'h55;
      tid_i = 64'h66;
      step(1'b1, 64'h20, 1'b0, 8'd16);
      chk("pid_old", 64'(fetchPid_o), 64'h0);
      step(1'b1, 64'h20, 1'b1, 8'd20);
      chk("pid_t1", 64'(fetchPid_o), 64'h0);
      step(1'b1, 64'h30, 1'b0, 8'd24);
      chk("pid_new", 64'(fetchPid_o), 64'h55);
      chk("tid_new", fetchTid_o, 64'h66);

      // partial bundle with only T0 enabled
      threadEnable_i = 2'b01;
      redirect(1'b0, 64'h100);
      step(1'b0, 64'h0, 1'b0, 8'd0);
      step(1'b1, 64'h100, 1'b0, 8'd28);
      incEnable_i = 1'b1;
      incCount_i = 3'd2;
      step(1'b0, 64'h0, 1'b0, 8'd0);
      step(1'b1, 64'h108, 1'b0, 8'd32);

      // redirected T1 is skipped, T0 issues instead
      threadEnable_i = 2'b11;
      redirect(1'b1, 64'h2003);
      step(1'b1, 64'h118, 1'b0, 8'd36);
      step(1'b1, 64'h2000, 1'b1, 8'd40);

      // stall holds T0@0x40; enable drop does not cancel it
      redirect(1'b0, 64'h40);
      step(1'b1, 64'h2010, 1'b1, 8'd44);
      step(1'b1, 64'h40, 1'b0, 8'd48);
      stall_i = 1'b1;
      step(1'b1, 64'h40, 1'b0, 8'd48);
      threadEnable_i = 2'b00;
      step(1'b1, 64'h40, 1'b0, 8'd48);
      threadEnable_i = 2'b11;
      step(1'b1, 64'h40, 1'b0, 8'd48);
      stall_i = 1'b0;
      step(1'b1, 64'h2020, 1'b1, 8'd52);
      step(1'b1, 64'h50, 1'b0, 8'd56);

      // redirect of the held thread drops the stalled fetch
      step(1'b1, 64'h2030, 1'b1, 8'd60);
      stall_i = 1'b1;
      redirect(1'b1, 64'h3000);
      step(1'b0, 64'h0, 1'b0, 8'd0);
      stall_i = 1'b0;
      step(1'b1, 64'h60, 1'b0, 8'd64);
      step(1'b1, 64'h3000, 1'b1, 8'd68);

      // run the counter up to 248
      for (int i = 0; i < 44; i++) begin
         step(1'b1, (i % 2 == 0) ? 64'h70 + 64'(16 * (i / 2))
                                 : 64'h3010 + 64'(16 * (i / 2)),
              1'(i % 2), 8'(72 + 4 * i));
      end

      // redirect wins over partial bundle; major ID wraps
      redirect(1'b0, 64'h40);
      step(1'b1, 64'h3170, 1'b1, 8'd248);
      step(1'b1, 64'h40, 1'b0, 8'd252);
      incEnable_i = 1'b1;
      incCount_i = 3'd1;
      redirect(1'b0, 64'h500);
      step(1'b0, 64'h0, 1'b0, 8'd0);
      step(1'b1, 64'h3180, 1'b1, 8'd0);
      step(1'b1, 64'h500, 1'b0, 8'd4);

      // reset beats a concurrent stall and redirect
      reset_i = 1'b1;
      stall_i = 1'b1;
      redirect(1'b0, 64'h900);
      step(1'b0, 64'h0, 1'b0, 8'd0);
      chk("rst2_addr", fetchAddress_o, 64'h0);
      chk("rst2_pid", 64'(fetchPid_o), 64'h0);
      reset_i = 1'b0;
      stall_i = 1'b0;
      step(1'b1, 64'h0, 1'b0, 8'd0);
      step(1'b1, 64'h0, 1'b1, 8'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_pc_sequencer.md
FETCH_PC_SEQUENCER -- requirements
Module: fetch_pc_sequencer

Interface
REQ-001 Parameter addressWidth, default 64, fetch address width in bits.
REQ-002 Parameter bundleInsts, default 4, instructions per fetch bundle; each instruction is 4 bytes.
REQ-003 Parameter numThreads, default 2, hardware thread contexts (1..8); TW = max(1, clog2(numThreads)).
REQ-004 Parameters PidSize (default 32), TidSize (default 64), instructionCounterWidth (default 64), resetVector (default 0).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 clock_i  in  1  sole clock; all state updates on rising edge.
REQ-007 reset_i  in  1  synchronous active-high reset.
REQ-008 stall_i  in  1  downstream not accepting; hold current fetch outputs.
REQ-009 threadEnable_i  in  numThreads  per-thread fetch enable.
REQ-010 redirectEn_i / redirectThread_i / redirectAddress_i  in  1 / TW / addressWidth  branch redirect of one thread's PC.
REQ-011 incEnable_i / incCount_i  in  1 / clog2(bundleInsts+1)  I-cache partial-bundle report for the fetch currently on the outputs.
REQ-012 pidWriteEn_i, tidWriteEn_i / idThread_i / pid_i / tid_i  in  1,1 / TW / PidSize / TidSize  per-thread ID update.
REQ-013 fetchValid_o  out  1  fetch request valid.
REQ-014 fetchAddress_o / fetchThread_o  out  addressWidth / TW  bundle start address and issuing thread.
REQ-015 fetchPid_o / fetchTid_o / fetchMajId_o  out  PidSize / TidSize / instructionCounterWidth  IDs of the issuing thread; first major ID of the bundle.

Function
REQ-016 Per-thread state SHALL be: PC[t], PID[t], TID[t]. Shared state SHALL be a round-robin pointer and a major-ID counter. All outputs SHALL be registered.
REQ-017 A cycle SHALL be an issue cycle when stall_i=0, incEnable_i=0, and at least one eligible thread exists. An eligible thread is enabled and not the target of a redirect in that cycle.
REQ-018 Thread selection SHALL be round-robin. Pick the first eligible thread strictly after the last issued thread, wrapping at numThreads-1. When numThreads=1, the selected thread is always 0.
REQ-019 On an issue cycle for thread s, the following SHALL be registered:
  - fetchValid_o=1, fetchAddress_o=PC[s], fetchThread_o=s, fetchPid_o=PID[s], fetchTid_o=TID[s], fetchMajId_o=counter.
  - PC[s] += 4*bundleInsts, modulo 2^addressWidth.
  - counter += bundleInsts, modulo 2^instructionCounterWidth.
REQ-020 When stall_i=1, all fetch outputs, PCs, the counter and the pointer SHALL hold, except for updates made by REQ-022 and REQ-023.
REQ-021 When stall_i=0 and no issue occurs, fetchValid_o SHALL be 0 on the next cycle; the other outputs are don't-care.
REQ-022 Partial bundle: incEnable_i=1 SHALL set PC[fetchThread_o] = fetchAddress_o + 4*incCount_i. That cycle is a bubble (fetchValid_o=0 next cycle unless stalled). The counter SHALL NOT be rolled back.
REQ-023 Redirect: redirectEn_i=1 SHALL set PC[redirectThread_i] = redirectAddress_i with bits [1:0] forced to 0. The redirected thread SHALL NOT issue in that cycle; other threads may.
REQ-024 If redirect and partial-bundle correction target the same thread in one cycle, the redirect SHALL win.
REQ-025 A redirect to thread fetchThread_o while fetchValid_o=1 and stall_i=1 SHALL drop the held fetch: fetchValid_o=0 next cycle.
REQ-026 PID/TID writes SHALL update PID[idThread_i] / TID[idThread_i]. They are visible to issues from the next cycle onward, not the same cycle.
REQ-027 A threadEnable_i bit falling SHALL NOT cancel a fetch already on the outputs.

Reset
REQ-028 With reset_i=1 at a clock edge, the following SHALL be set:
  - PC[all] = resetVector; PID/TID[all] = 0; counter = 0.
  - Round-robin pointer = numThreads-1, so thread 0 is selected first.
  - fetchValid_o=0 and all other outputs 0.
  - All other inputs are ignored.
REQ-029 A reset asserted mid-stall or mid-redirect SHALL take priority over every other update in that cycle.

Verification
REQ-030 Reset, numThreads=2, both threads enabled, no stall. Required response: fetches alternate T0@0x0 (majId 0), T1@0x0 (4), T0@0x10 (8), T1@0x10 (12).
REQ-031 Only T0 enabled; issue at 0x100; next cycle incEnable_i=1 with incCount_i=2. Required response: one bubble, then T0 fetch @0x108.
REQ-032 Redirect T1 to 0x2003 while T1 is selected. Required response: T1 skipped that cycle (T0 issues); T1's next fetch is @0x2000.
REQ-033 stall_i=1 for 3 cycles with T0 fetch @0x40 on the outputs. Required response: outputs frozen 3 cycles, no PC advance; after release the next fetch is T1.
REQ-034 Same-cycle redirect of T0 to 0x500 and incEnable_i=1 for T0 fetch @0x40, plus counter wrap from 2^64-4. Required response: PC[T0]=0x500; fetchMajId_o wraps to 0.
